// File: rtl/mem_port_arbiter.sv
// Two-port (I/D) arbiter in front of the shared data memory: one transaction in flight,
// round-robin on contention, completions steered back to the owning port.
module mem_port_arbiter #(
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [WORD_WIDTH-1:0] i_req_addr,
  input  logic [WORD_WIDTH-1:0] i_req_wdata,
  input  logic [2:0]            i_req_wtype,
  output logic                  i_req_ready,
  output logic                  i_resp_valid,
  output logic [LINE_WIDTH-1:0] i_resp_data,
  input  logic                  d_req_valid,
  input  logic                  d_req_write,
  input  logic [WORD_WIDTH-1:0] d_req_addr,
  input  logic [WORD_WIDTH-1:0] d_req_wdata,
  input  logic [2:0]            d_req_wtype,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [LINE_WIDTH-1:0] d_resp_data,
  output logic [WORD_WIDTH-1:0] mem_read_address,
  output logic                  mem_read_request,
  input  logic                  mem_read_enable,
  input  logic [LINE_WIDTH-1:0] mem_read_data,
  output logic [WORD_WIDTH-1:0] mem_write_address,
  output logic                  mem_write_request,
  output logic [WORD_WIDTH-1:0] mem_write_data,
  output logic [2:0]            mem_write_type,
  input  logic                  mem_write_done
);
  localparam int OFS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_BUSY, RD_DONE, WR_BUSY, WR_DONE, RESP, GAP} state_t;

  typedef struct packed {
    logic                  write;
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic [2:0]            wtype;
  } req_t;

  state_t state, state_nxt;
  req_t   req_i, req_d, sel;
  logic   grant_i, grant_d;
  logic   rr_d;    // 1: contention goes to D
  logic   own_d, own_wr;

  assign req_i = '{write: i_req_write, addr: i_req_addr, wdata: i_req_wdata, wtype: i_req_wtype};
  assign req_d = '{write: d_req_write, addr: d_req_addr, wdata: d_req_wdata, wtype: d_req_wtype};
  assign sel   = grant_d ? req_d : req_i;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt         = state;
    grant_i           = 1'b0;
    grant_d           = 1'b0;
    mem_read_request  = 1'b0;
    mem_write_request = 1'b0;
    i_resp_valid      = 1'b0;
    d_resp_valid      = 1'b0;
    case (state)
      IDLE: begin
        // Grants are suppressed while reset is held so nothing is accepted into a dead FSM.
        if (!reset) begin
          if (i_req_valid && d_req_valid) begin
            grant_d = rr_d;
            grant_i = !rr_d;
          end else begin
            grant_i = i_req_valid;
            grant_d = d_req_valid && !i_req_valid;
          end
        end
        if (grant_i || grant_d) state_nxt = sel.write ? WR_BUSY : RD_ISSUE;
      end
      RD_ISSUE: begin
        mem_read_request = 1'b1;
        state_nxt        = RD_BUSY;
      end
      RD_BUSY: if (!mem_read_enable) state_nxt = RD_DONE;
      RD_DONE: if (mem_read_enable)  state_nxt = RESP;
      WR_BUSY: begin
        mem_write_request = 1'b1;
        if (!mem_write_done) state_nxt = WR_DONE;
      end
      WR_DONE: begin
        mem_write_request = 1'b1;
        if (mem_write_done) state_nxt = RESP;
      end
      RESP: begin
        i_resp_valid = !own_d;
        d_resp_valid = own_d;
        state_nxt    = own_wr ? GAP : IDLE;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // Memory-side fields only move on a grant of the matching kind, so they hold between ops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_d              <= 1'b0;
      own_d             <= 1'b0;
      own_wr            <= 1'b0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_write_type    <= '0;
      i_resp_data       <= '0;
      d_resp_data       <= '0;
    end else begin
      if (grant_i || grant_d) begin
        own_d  <= grant_d;
        own_wr <= sel.write;
        rr_d   <= grant_i;
        if (sel.write) begin
          mem_write_address <= sel.addr;
          mem_write_data    <= sel.wdata;
          mem_write_type    <= sel.wtype;
        end else begin
          mem_read_address  <= {sel.addr[WORD_WIDTH-1:OFS], {OFS{1'b0}}};
        end
      end
      if (state == RD_DONE && mem_read_enable) begin
        if (own_d) d_resp_data <= mem_read_data;
        else       i_resp_data <= mem_read_data;
      end
      if (state == WR_DONE && mem_write_done) begin
        if (own_d) d_resp_data <= '0;
        else       i_resp_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory plus per-port response scoreboards.
module tb_mem_port_arbiter;
  localparam int LW = 512;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_req_valid = 0, i_req_write = 0, d_req_valid = 0, d_req_write = 0;
  logic [31:0]   i_req_addr = '0, i_req_wdata = '0, d_req_addr = '0, d_req_wdata = '0;
  logic [2:0]    i_req_wtype = '0, d_req_wtype = '0;
  logic          i_req_ready, i_resp_valid, d_req_ready, d_resp_valid;
  logic [LW-1:0] i_resp_data, d_resp_data;
  logic [31:0]   mem_read_address, mem_write_address, mem_write_data;
  logic          mem_read_request, mem_write_request;
  logic          mem_read_enable = 1'b1, mem_write_done = 1'b1;
  logic [LW-1:0] mem_read_data = '0;
  logic [2:0]    mem_write_type;

  mem_port_arbiter #(.LINE_WIDTH(LW), .WORD_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_wtype(i_req_wtype), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wtype(d_req_wtype), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_read_address(mem_read_address), .mem_read_request(mem_read_request),
    .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data),
    .mem_write_address(mem_write_address), .mem_write_request(mem_write_request),
    .mem_write_data(mem_write_data), .mem_write_type(mem_write_type),
    .mem_write_done(mem_write_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int vectors = 0, miscompares = 0;
  int hold_err = 0, overlap_err = 0, pulse_err = 0;
  logic [LW-1:0] exp_i[$], exp_d[$];
  bit grants[$];

  function automatic logic [LW-1:0] line_of(input logic [31:0] a);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = (a ^ 32'hA5A5_5A5A) + 32'(k);
    return r;
  endfunction

  // Memory model: reacts on the falling edge so the DUT samples settled inputs.
  int rd_lat = 2, wr_lat = 1, rd_cnt = 0, wr_cnt = 0, n_writes = 0;
  bit wr_seen = 0;
  logic [31:0] rd_addr_l = '0;
  always @(negedge clock) begin
    if (reset) begin
      rd_cnt = 0; wr_cnt = 0; wr_seen = 0;
      mem_read_enable = 1'b1; mem_write_done = 1'b1;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin mem_read_enable = 1'b1; mem_read_data = line_of(rd_addr_l); end
      end else if (mem_read_request) begin
        mem_read_enable = 1'b0; rd_cnt = rd_lat; rd_addr_l = mem_read_address; mem_read_data = '1;
      end
      if (!mem_write_request) wr_seen = 0;
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) mem_write_done = 1'b1;
      end else if (mem_write_request && !wr_seen) begin
        wr_seen = 1; mem_write_done = 1'b0; wr_cnt = wr_lat; n_writes++;
      end
    end
  end

  // Response scoreboard and protocol watchers.
  logic [LW-1:0] prev_i = '0, prev_d = '0, mon_e;
  logic prev_rrq = 0;
  always @(negedge clock) begin
    if (reset) begin
      prev_i = i_resp_data; prev_d = d_resp_data; prev_rrq = 0;
    end else begin
      if (i_resp_valid) begin
        vectors++;
        if (exp_i.size() == 0) begin
          miscompares++; $display("FAIL i_resp_unexpected: got resp_valid=1, expected none");
        end else begin
          mon_e = exp_i.pop_front();
          if (i_resp_data !== mon_e) begin
            miscompares++; $display("FAIL i_resp_data: got %h expected %h", i_resp_data, mon_e);
          end
        end
      end else if (i_resp_data !== prev_i) hold_err++;
      if (d_resp_valid) begin
        vectors++;
        if (exp_d.size() == 0) begin
          miscompares++; $display("FAIL d_resp_unexpected: got resp_valid=1, expected none");
        end else begin
          mon_e = exp_d.pop_front();
          if (d_resp_data !== mon_e) begin
            miscompares++; $display("FAIL d_resp_data: got %h expected %h", d_resp_data, mon_e);
          end
        end
      end else if (d_resp_data !== prev_d) hold_err++;
      if (i_req_ready && d_req_ready) overlap_err++;
      if (mem_read_request && mem_write_request) overlap_err++;
      if (mem_read_request && prev_rrq) pulse_err++;
      prev_rrq = mem_read_request; prev_i = i_resp_data; prev_d = d_resp_data;
    end
  end

  task automatic drive(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] wt, input bit keep, output int gcyc);
    logic [LW-1:0] e;
    e = wr ? '0 : line_of({addr[31:6], 6'b0});
    if (!port) begin
      i_req_write = wr; i_req_addr = addr; i_req_wdata = wd; i_req_wtype = wt; i_req_valid = 1;
      exp_i.push_back(e);
    end else begin
      d_req_write = wr; d_req_addr = addr; d_req_wdata = wd; d_req_wtype = wt; d_req_valid = 1;
      exp_d.push_back(e);
    end
    gcyc = -1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (port ? d_req_ready : i_req_ready) begin gcyc = cyc; grants.push_back(port); break; end
      @(negedge clock);
    end
    vectors++;
    if (gcyc < 0) begin miscompares++; $display("FAIL grant_timeout: port %0d got no ready, expected ready", port); end
    @(posedge clock); #1;
    if (!keep) begin if (!port) i_req_valid = 0; else d_req_valid = 0; end
  endtask

  task automatic wait_resp(input bit port, output int rcyc, output int npulse, output logic [31:0] raddr,
                           output int nwr, output logic [31:0] wa, output logic [31:0] wdv, output logic [2:0] wtv);
    rcyc = -1; npulse = 0; nwr = 0; raddr = 'x; wa = 'x; wdv = 'x; wtv = 'x;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (mem_read_request) begin npulse++; raddr = mem_read_address; end
      if (mem_write_request) begin nwr++; wa = mem_write_address; wdv = mem_write_data; wtv = mem_write_type; end
      if (port ? d_resp_valid : i_resp_valid) begin rcyc = cyc; break; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock); #2 reset = 1;
    @(negedge clock); #2 reset = 0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_read_request, mem_write_request} !== 6'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 000000",
        {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_read_request, mem_write_request});
    end
    vectors++;
    if ({mem_read_address, mem_write_address, mem_write_data, mem_write_type} !== '0) begin
      miscompares++; $display("FAIL reset_mem_fields: got %h/%h/%h/%h expected zero",
        mem_read_address, mem_write_address, mem_write_data, mem_write_type);
    end
    vectors++;
    if ({i_resp_data, d_resp_data} !== '0) begin miscompares++; $display("FAIL reset_resp_data: got nonzero expected zero"); end
    @(negedge clock); #2 reset = 0;
    @(negedge clock);
  endtask

  task automatic test_i_read();
    int g, r, np, nw; logic [31:0] ra, wa, wd; logic [2:0] wt;
    rd_lat = 2;
    drive(0, 0, 32'h0000_0047, '0, '0, 0, g);
    wait_resp(0, r, np, ra, nw, wa, wd, wt);
    vectors++;
    if (r - g != 4) begin miscompares++; $display("FAIL i_read_latency: got %0d expected 4", r - g); end
    vectors++;
    if (ra !== 32'h0000_0040) begin miscompares++; $display("FAIL i_read_addr: got %h expected 00000040", ra); end
    vectors++;
    if (np != 1 || nw != 0) begin miscompares++; $display("FAIL i_read_pulses: got rd=%0d wr=%0d expected rd=1 wr=0", np, nw); end
    vectors++;
    if (d_resp_data !== '0 || d_resp_valid !== 1'b0) begin miscompares++; $display("FAIL i_read_d_untouched: got valid=%b expected d port idle", d_resp_valid); end
  endtask

  task automatic test_d_read_hold();
    int g, r, np, nw; logic [31:0] ra, wa, wd; logic [2:0] wt;
    rd_lat = 3;
    drive(1, 0, 32'h1234_5678, '0, '0, 0, g);
    wait_resp(1, r, np, ra, nw, wa, wd, wt);
    vectors++;
    if (r - g != 5) begin miscompares++; $display("FAIL d_read_latency: got %0d expected 5", r - g); end
    vectors++;
    if (ra !== 32'h1234_5640) begin miscompares++; $display("FAIL d_read_addr: got %h expected 12345640", ra); end
    rd_lat = 2;
    drive(0, 0, 32'h0000_0200, '0, '0, 0, g);
    wait_resp(0, r, np, ra, nw, wa, wd, wt);
    vectors++;
    if (d_resp_data !== line_of(32'h1234_5640)) begin miscompares++; $display("FAIL d_resp_hold: got %h expected held D line", d_resp_data); end
  endtask

  task automatic test_d_write();
    int g, r, np, nw; logic [31:0] ra, wa, wd; logic [2:0] wt;
    wr_lat = 2;
    drive(1, 1, 32'h0000_0084, 32'hDEAD_BEEF, 3'b010, 0, g);
    wait_resp(1, r, np, ra, nw, wa, wd, wt);
    vectors++;
    if (r - g != 4) begin miscompares++; $display("FAIL d_write_latency: got %0d expected 4", r - g); end
    vectors++;
    if (nw != 3 || np != 0) begin miscompares++; $display("FAIL d_write_req_cycles: got wr=%0d rd=%0d expected wr=3 rd=0", nw, np); end
    vectors++;
    if ({wa, wd, wt} !== {32'h0000_0084, 32'hDEAD_BEEF, 3'b010}) begin
      miscompares++; $display("FAIL d_write_fields: got %h %h %b expected 00000084 deadbeef 010", wa, wd, wt);
    end
    vectors++;
    if (d_resp_data !== '0) begin miscompares++; $display("FAIL d_write_resp_zero: got nonzero expected zero"); end
    @(negedge clock);
    vectors++;
    if (mem_write_request !== 1'b0 || d_resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL d_write_gap: got req=%b valid=%b expected 0 0", mem_write_request, d_resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int g1, g2, r, np, nw, n0; logic [31:0] ra, wa, wd; logic [2:0] wt;
    wr_lat = 1; n0 = n_writes;
    drive(1, 1, 32'h0000_0100, 32'h0000_0011, 3'b001, 1, g1);
    drive(1, 1, 32'h0000_0104, 32'h0000_0022, 3'b010, 0, g2);
    wait_resp(1, r, np, ra, nw, wa, wd, wt);
    vectors++;
    if (g2 - g1 != 5) begin miscompares++; $display("FAIL b2b_grant_spacing: got %0d expected 5", g2 - g1); end
    vectors++;
    if (r - g2 != 3) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 3", r - g2); end
    vectors++;
    if (n_writes - n0 != 2) begin miscompares++; $display("FAIL b2b_write_count: got %0d expected 2", n_writes - n0); end
    vectors++;
    if ({mem_write_address, mem_write_data} !== {32'h0000_0104, 32'h0000_0022}) begin
      miscompares++; $display("FAIL b2b_hold_fields: got %h %h expected 00000104 00000022", mem_write_address, mem_write_data);
    end
  endtask

  task automatic test_reset_mid();
    int g, r, np, nw; logic [31:0] ra, wa, wd; logic [2:0] wt;
    rd_lat = 6;
    drive(0, 0, 32'h0000_0A80, '0, '0, 0, g);
    @(negedge clock); @(negedge clock);
    #2 reset = 1;
    exp_i.delete();
    #1;
    vectors++;
    if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_read_request, mem_write_request} !== 6'b0) begin
      miscompares++; $display("FAIL mid_reset_ctrl: got %b expected 000000",
        {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_read_request, mem_write_request});
    end
    vectors++;
    if ({mem_read_address, mem_write_address, mem_write_data, mem_write_type} !== '0 || {i_resp_data, d_resp_data} !== '0) begin
      miscompares++; $display("FAIL mid_reset_fields: got rd_addr=%h wr_addr=%h expected zero", mem_read_address, mem_write_address);
    end
    @(negedge clock); #2 reset = 0;
    repeat (12) @(negedge clock);
    rd_lat = 2;
    drive(0, 0, 32'h0000_0C13, '0, '0, 0, g);
    wait_resp(0, r, np, ra, nw, wa, wd, wt);
    vectors++;
    if (r - g != 4 || ra !== 32'h0000_0C00) begin
      miscompares++; $display("FAIL post_reset_read: got lat=%0d addr=%h expected lat=4 addr=00000c00", r - g, ra);
    end
  endtask

  task automatic test_contention();
    bit exp_seq[6] = '{0, 1, 0, 1, 0, 1};
    pulse_reset();
    grants.delete();
    rd_lat = 2; wr_lat = 1;
    fork
      begin
        int g;
        for (int k = 0; k < 3; k++) drive(0, 0, 32'h0000_1000 + 32'(k) * 32'h40, '0, '0, k < 2, g);
      end
      begin
        int g;
        for (int k = 0; k < 3; k++) drive(1, 1, 32'h0000_2000 + 32'(k) * 4, 32'hC0DE_0000 + 32'(k), 3'b011, k < 2, g);
      end
    join
    for (int k = 0; k < 40 && (exp_i.size() != 0 || exp_d.size() != 0); k++) @(negedge clock);
    vectors++;
    if (grants.size() != 6) begin miscompares++; $display("FAIL rr_grant_count: got %0d expected 6", grants.size()); end
    for (int k = 0; k < 6 && k < grants.size(); k++) begin
      vectors++;
      if (grants[k] !== exp_seq[k]) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grants[k], exp_seq[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_read_hold();
    test_d_write();
    test_back_to_back();
    test_reset_mid();
    test_contention();
    repeat (4) @(negedge clock);
    vectors++;
    if (exp_i.size() + exp_d.size() != 0) begin
      miscompares++; $display("FAIL pending_responses: got %0d outstanding expected 0", exp_i.size() + exp_d.size());
    end
    vectors++;
    if (overlap_err != 0) begin miscompares++; $display("FAIL overlap: got %0d events expected 0", overlap_err); end
    vectors++;
    if (hold_err != 0) begin miscompares++; $display("FAIL resp_data_hold: got %0d changes expected 0", hold_err); end
    vectors++;
    if (pulse_err != 0) begin miscompares++; $display("FAIL read_pulse_width: got %0d long pulses expected 0", pulse_err); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer in front of the shared data memory. It accepts line reads and word writes from the instruction-cache port (I) and the data-cache port (D), serialises them onto the memory's single read path and single write path, and steers each completion back to the requester that owns it. At most one memory transaction is outstanding at any time.

## Interface
- `LINE_WIDTH`, 512, width of one memory line and of read responses.
- `WORD_WIDTH`, 32, width of write data and of addresses.

Ports (`*` = `i` or `d`; both requester ports are identical):
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `*_req_valid`  in  1  request pending; must stay high with fields stable until accepted.
- `*_req_write`  in  1  1 = word write, 0 = line read.
- `*_req_addr`  in  32  byte address.
- `*_req_wdata`  in  32  write data.
- `*_req_wtype`  in  3  write type, passed through to memory.
- `*_req_ready`  out  1  accept strobe (combinational, IDLE only).
- `*_resp_valid`  out  1  one-cycle completion pulse.
- `*_resp_data`  out  512  read line; zero for write completions.
- `mem_read_address`  out  32  line-aligned read address.
- `mem_read_request`  out  1  one-cycle read-start pulse.
- `mem_read_enable`  in  1  memory read idle (1) or busy (0).
- `mem_read_data`  in  512  line returned by memory.
- `mem_write_address`  out  32  write byte address.
- `mem_write_request`  out  1  level; held high until the write completes.
- `mem_write_data`  out  32  word to write.
- `mem_write_type`  out  3  write type.
- `mem_write_done`  in  1  memory write idle (1) or busy (0).

## Operation
- States: IDLE, RD_ISSUE, RD_BUSY, RD_DONE, WR_BUSY, WR_DONE, RESP, GAP.
- IDLE, only one port valid: grant that port.
- IDLE, both ports valid: grant the port the round-robin pointer favours. The pointer resets to favour I and, after every granted transaction, flips to favour the other port.
- Grant in cycle T: assert the winner's `*_req_ready` in T only, and capture owner, write flag, address, wdata and wtype.
- Read path:
  - RD_ISSUE: drive `mem_read_address` = {addr[31:6], 6'b0} and pulse `mem_read_request`.
  - RD_BUSY: wait for `mem_read_enable`==0.
  - RD_DONE: wait for `mem_read_enable`==1, then latch `mem_read_data` and go to RESP.
- Write path:
  - On grant, drive the captured address, data and wtype, and raise `mem_write_request`.
  - WR_BUSY: wait for `mem_write_done`==0.
  - WR_DONE: wait for `mem_write_done`==1, then drop `mem_write_request` and go to RESP.
- RESP: pulse the owner's `*_resp_valid` for one cycle with `*_resp_data` (the latched line, or zero for a write). Next state is GAP after a write, IDLE after a read.
- GAP: one idle cycle with `mem_write_request` low, so every write starts on a fresh rising edge. Next state is IDLE.
- `mem_read_address`, `mem_write_address`, `mem_write_data` and `mem_write_type` hold their last value between transactions.
- Only the owner's response outputs change. The other port's `*_resp_data` holds its value.
- A port whose valid drops before acceptance is not granted; requests are not stored.

## Timing
- Reset values: state IDLE, pointer favours I, all `*_req_ready`, `*_resp_valid`, `mem_read_request` and `mem_write_request` = 0. All address, data and `*_resp_data` outputs = 0.
- Reset asserted mid-transaction: return to IDLE immediately. The in-flight op is abandoned, no response is issued, and `mem_write_request` falls asynchronously.
- Read latency, accept to `resp_valid`: 1 (RD_ISSUE) + cycles until busy seen + cycles until idle seen + 1 (RESP). Minimum 4 cycles.
- Write latency: minimum 3 cycles to `resp_valid`, plus the GAP cycle before the next grant.
- Busy-then-idle is required. A memory that never drops its idle flag stalls the arbiter; there is no timeout.
- A new request that is valid during RESP or GAP is granted no earlier than the next IDLE cycle.
- `*_req_ready` is never high for both ports in the same cycle. The memory never sees a read and a write active in the same cycle.

## Test plan
- I line read of 0x0000_0047, memory busy for 2 cycles: `mem_read_address`=0x0000_0040, one `mem_read_request` pulse, `i_resp_valid` one cycle with the returned line, `d_*` outputs unchanged.
- D write of 0xDEAD_BEEF to 0x0000_0084 with wtype 3'b010: `mem_write_request` high until `mem_write_done` returns, `d_resp_valid` pulse with data 0, then one GAP cycle with `mem_write_request` low.
- I and D valid every cycle (I read, D write): grants alternate I, D, I, D starting with I after reset, with no overlap on the memory interface.
- Back-to-back D writes: `mem_write_request` shows a low cycle between the two, and both writes complete.
- `reset` pulsed while in RD_BUSY: all outputs return to reset values in the same cycle, no `resp_valid` is issued, and a new I read afterwards completes normally.
